// File: rtl/myproject_sdiv_19s_8s_12_seq.sv
// Sequential signed divider: 19-bit signed dividend / 8-bit signed divisor,
// producing a saturated 12-bit signed quotient and an 8-bit signed remainder.
// Radix-2 restoring division, one quotient bit per clock, valid/ready on both sides.
// Optional build macro MYPROJECT_SDIV_ZERO_BYPASS_EN: a zero dividend or zero
// divisor skips the iteration and goes straight to the fix-up cycle.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for operands
// CALC   | one restoring step per clock, MSB first, DIVIDEND_WIDTH steps
// FIX    | apply signs, saturate, register outputs
// DONE   | out_valid=1, hold outputs until out_ready
module myproject_sdiv_19s_8s_12_seq #(
  parameter int DIVIDEND_WIDTH = 19,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int QUOTIENT_WIDTH = 12
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      q_ovf
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int SW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int CW = $clog2(DW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0]        CNT_LAST = CW'(DW - 1);
  localparam logic signed [DW:0]   Q_MAX    = (DW+1)'((1 << (QW-1)) - 1);
  localparam logic signed [DW:0]   Q_MIN    = ~Q_MAX;
  localparam logic [QW-1:0]        SAT_POS  = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0]        SAT_NEG  = {1'b1, {(QW-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [SW-1:0] dsr_q, dsr_d;
  logic [SW-1:0] rem_q, rem_d;
  logic          sgn_dvd_q, sgn_dvd_d;
  logic          sgn_dsr_q, sgn_dsr_d;
  logic          zero_q, zero_d;
  logic          out_valid_q, out_valid_d;
  logic [QW-1:0] quo_out_q, quo_out_d;
  logic [SW-1:0] rem_out_q, rem_out_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic                 accept;
  logic                 bypass;
  logic [DW-1:0]        dvd_abs;
  logic [SW-1:0]        dsr_abs;
  logic [SW:0]          part;
  logic                 keep;
  logic [SW-1:0]        diff;
  logic [DW:0]          q_mag;
  logic signed [DW:0]   q_signed;

  assign in_ready = (state_q == S_IDLE) && ap_rst_n;
  assign accept   = in_valid && in_ready;

`ifdef MYPROJECT_SDIV_ZERO_BYPASS_EN
  assign bypass = (divisor == '0) || (dividend == '0);
`else
  assign bypass = 1'b0;
`endif

  assign dvd_abs = dividend[DW-1] ? -dividend : dividend;
  assign dsr_abs = divisor[SW-1]  ? -divisor  : divisor;

  // The stored remainder is always below |divisor| <= 2^(SW-1), so SW bits hold it;
  // the SW+1-bit partial remainder only exists for the trial compare. When the
  // trial succeeds the true difference is below 2^(SW-1), so an SW-bit subtract is exact.
  assign part = {rem_q, dvd_q[DW-1]};
  assign keep = (part >= {1'b0, dsr_q});
  assign diff = part[SW-1:0] - dsr_q;

  assign q_mag    = {1'b0, quo_q};
  assign q_signed = (sgn_dvd_q ^ sgn_dsr_q) ? -q_mag : q_mag;

  // Next-state and datapath for the handshake / iteration / fix-up sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    sgn_dvd_d   = sgn_dvd_q;
    sgn_dsr_d   = sgn_dsr_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    quo_out_d   = quo_out_q;
    rem_out_d   = rem_out_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sgn_dvd_d = dividend[DW-1];
          sgn_dsr_d = divisor[SW-1];
          dvd_d     = dvd_abs;
          dsr_d     = dsr_abs;
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = CNT_LAST;
          zero_d    = (divisor == '0);
          state_d   = bypass ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = keep ? diff : part[SW-1:0];
        quo_d = {quo_q[DW-2:0], keep};
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        out_valid_d = 1'b1;
        state_d     = S_DONE;
        dbz_d       = zero_q;
        ovf_d       = 1'b0;
        if (zero_q) begin
          quo_out_d = sgn_dvd_q ? SAT_NEG : SAT_POS;
          rem_out_d = '0;
        end else begin
          rem_out_d = sgn_dvd_q ? -rem_q : rem_q;
          if (q_signed > Q_MAX) begin
            quo_out_d = SAT_POS;
            ovf_d     = 1'b1;
          end else if (q_signed < Q_MIN) begin
            quo_out_d = SAT_NEG;
            ovf_d     = 1'b1;
          end else begin
            quo_out_d = q_signed[QW-1:0];
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      sgn_dvd_q   <= 1'b0;
      sgn_dsr_q   <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      quo_out_q   <= '0;
      rem_out_q   <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      sgn_dvd_q   <= sgn_dvd_d;
      sgn_dsr_q   <= sgn_dsr_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      quo_out_q   <= quo_out_d;
      rem_out_q   <= rem_out_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;
  assign q_ovf       = ovf_q;

endmodule
